pc_weight_enum: RTL and testbench

- Inverse companion to the parallel-counter family: given a target count k, streams every N-bit input vector whose population count equals k, one vector per accepted beat.
- Beats come out in ascending numerical order.
- Drives exhaustive and weight-targeted stimulus into (7;3)-style counters, and serves as a unary/combination source for sorting-network experiments.
- Command in over a valid/ready handshake; patterns out over a valid/ready stream with last/error flags.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_comb_next.sv | 45 ++++
 rtl/pc_weight_enum.sv | 86 ++++++++
 tb/tb_pc_weight_enum.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the weight-enumerator family.
// No logic of its own; constants and a first-pattern helper only.
// Not applicable (package).
package pc_pkg;

   localparam int DEF_N  = 7;
   localparam int DEF_CW = $clog2(DEF_N + 1);
   localparam int MAX_N  = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Smallest pattern of weight k: the low k bits set. Computed one bit wider
   // so k == MAX_N still yields all ones without overflowing the shift.
   function automatic logic [MAX_N-1:0] first_pattern(input logic [4:0] k);
      logic [MAX_N:0] t;
      t = ((MAX_N+1)'(1) << k) - (MAX_N+1)'(1);
      return t[MAX_N-1:0];
   endfunction

endpackage

// File: rtl/pc_comb_next.sv
// Gosper step: next larger N-bit value with the same popcount, plus last flag.
// Purely combinational, zero latency.
// No handshake; caller decides when to advance.
module pc_comb_next
   import pc_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  x,
   input  logic [CW-1:0] k,
   output logic [N-1:0]  next,
   output logic          is_last   // next is the top-k pattern
);

   logic [N:0]    xw;
   logic [N:0]    c;
   logic [N:0]    r;
   logic [N:0]    spread;
   logic [CW-1:0] tz;
   logic [N-1:0]  last_mask;

   // Gosper step in N+1 bits; the divide by c is replaced by a shift of ctz(c)
   always_comb begin
      xw = {1'b0, x};
      c  = xw & (-xw);
      r  = xw + c;
      tz = '0;
      for (int i = N; i >= 0; i--) begin
         if (c[i]) tz = CW'(i);
      end
      spread = ((r ^ xw) >> 2) >> tz;
      next   = r[N-1:0] | spread[N-1:0];
   end

   // Final pattern of the enumeration has the top k bits set
   always_comb begin
      last_mask = '0;
      for (int i = 0; i < N; i++) begin
         last_mask[i] = ((i + int'(k)) >= N);
      end
      is_last = (next == last_mask);
   end

endmodule

// File: rtl/pc_weight_enum.sv
// Streams every N-bit vector of popcount k in ascending order, one per beat.
// Beat 0 registered one cycle after command accept; then one beat per cycle.
// out_valid holds with stable data until out_ready; cmd_ready only in IDLE.
module pc_weight_enum
   import pc_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int CW = $clog2(N + 1),
   parameter int IW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [CW-1:0] cmd_k,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic [IW-1:0] out_index,
   output logic          out_last,
   output logic          out_err
);

   localparam logic [CW-1:0] KMAX = CW'(N);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] k_q;
   logic [N-1:0]  nxt;
   logic          nxt_last;
   logic [N-1:0]  fp;
   logic          cmd_hs;
   logic          out_hs;

   assign cmd_ready = (state == IDLE);
   assign out_valid = (state == EMIT);
   assign cmd_hs    = cmd_valid && cmd_ready;
   assign out_hs    = out_valid && out_ready;
   assign fp        = N'(first_pattern(5'(cmd_k)));

   pc_comb_next #(.N(N), .CW(CW)) u_next (
      .x       (out_data),
      .k       (k_q),
      .next    (nxt),
      .is_last (nxt_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: accept a command in IDLE, leave EMIT on the last handshake
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_hs) state_nxt = EMIT;
         EMIT:    if (out_hs && out_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Beat registers: load first pattern on accept, Gosper-advance on handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q       <= '0;
         out_data  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
         out_err   <= 1'b0;
      end else if (cmd_hs) begin
         k_q       <= cmd_k;
         out_data  <= (cmd_k > KMAX) ? '0 : fp;
         out_index <= '0;
         // k=0, k=N and illegal k all produce exactly one beat
         out_last  <= (cmd_k == '0) || (cmd_k >= KMAX);
         out_err   <= (cmd_k > KMAX);
      end else if (out_hs && !out_last) begin
         out_data  <= nxt;
         out_index <= out_index + IW'(1);
         out_last  <= nxt_last;
      end
   end

endmodule

// File: tb/tb_pc_weight_enum.sv
module tb_pc_weight_enum;

   logic        clk = 1'b0;
   logic        rst;
   // N=7 instance
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_k;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_data;
   logic [15:0] out_index;
   logic        out_last;
   logic        out_err;
   // N=5 instance (exercises the illegal k>N path)
   logic        cmd_valid5;
   logic        cmd_ready5;
   logic [2:0]  cmd_k5;
   logic        out_valid5;
   logic        out_ready5;
   logic [4:0]  out_data5;
   logic [15:0] out_index5;
   logic        out_last5;
   logic        out_err5;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   pc_weight_enum #(.N(7), .CW(3), .IW(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last), .out_err(out_err)
   );

   pc_weight_enum #(.N(5), .CW(3), .IW(16)) dut5 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid5), .cmd_ready(cmd_ready5), .cmd_k(cmd_k5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
      .out_index(out_index5), .out_last(out_last5), .out_err(out_err5)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int k);
      cmd_valid = 1'b1;
      cmd_k     = 3'(k);
      tick();
      cmd_valid = 1'b0;
   endtask

   // Reference enumeration: scan all 7-bit values upward, keep weight k
   task automatic build_exp(input int k);
      exp_q.delete();
      for (int v = 0; v < 128; v++)
         if ($countones(v) == k) exp_q.push_back(v);
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; cmd_k = '0; out_ready = 1'b0;
      cmd_valid5 = 1'b0; cmd_k5 = '0; out_ready5 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs got rdy=%b vld=%b want rdy=1 vld=0", cmd_ready, out_valid);
      end
      checks++;
      if (out_data !== 7'd0 || out_index !== 16'd0 || out_last !== 1'b0 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs got d=%h i=%0d l=%b e=%b want zeros", out_data, out_index, out_last, out_err);
      end
      checks++;
      if (cmd_ready5 !== 1'b1 || out_valid5 !== 1'b0 || out_data5 !== 5'd0) begin
         errors++;
         $display("FAIL reset_n5 got rdy=%b vld=%b d=%h want 1 0 0", cmd_ready5, out_valid5, out_data5);
      end
   endtask

   task automatic test_k3;
      int n;
      out_ready = 1'b1;
      build_exp(3);
      send_cmd(3);
      n = 0;
      while (out_valid === 1'b1 && n < 50) begin
         checks++;
         if (n >= exp_q.size() || out_data !== 7'(exp_q[n]) || out_index !== 16'(n)) begin
            errors++;
            $display("FAIL k3_beat n=%0d got d=%h i=%0d", n, out_data, out_index);
         end
         checks++;
         if (out_last !== (n == 34) || out_err !== 1'b0) begin
            errors++;
            $display("FAIL k3_flags n=%0d got l=%b e=%b want l=%b e=0", n, out_last, out_err, (n == 34));
         end
         checks++;
         if ($countones(out_data) != 3) begin
            errors++;
            $display("FAIL k3_counter n=%0d got count=%0d want 3", n, $countones(out_data));
         end
         n++;
         tick();
      end
      checks++;
      if (n != 35 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL k3_count got beats=%0d rdy=%b want 35 1", n, cmd_ready);
      end
   endtask

   task automatic test_sweep;
      int seen[128];
      int cnt_tbl[8] = '{1, 7, 21, 35, 35, 21, 7, 1};
      int n;
      int bad;
      for (int v = 0; v < 128; v++) seen[v] = 0;
      out_ready = 1'b1;
      for (int k = 0; k <= 7; k++) begin
         build_exp(k);
         send_cmd(k);
         n = 0;
         while (out_valid === 1'b1 && n < 50) begin
            checks++;
            if (n >= exp_q.size() || out_data !== 7'(exp_q[n]) || out_err !== 1'b0 ||
                out_last !== (n == cnt_tbl[k] - 1)) begin
               errors++;
               $display("FAIL sweep_beat k=%0d n=%0d got d=%h l=%b e=%b", k, n, out_data, out_last, out_err);
            end
            seen[out_data]++;
            n++;
            tick();
         end
         checks++;
         if (n != cnt_tbl[k]) begin
            errors++;
            $display("FAIL sweep_count k=%0d got %0d want %0d", k, n, cnt_tbl[k]);
         end
      end
      bad = 0;
      for (int v = 0; v < 128; v++) if (seen[v] != 1) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL sweep_cover got %0d values not seen exactly once want 0", bad);
      end
   endtask

   task automatic test_stall;
      int n;
      bit done;
      bit held;
      logic [6:0]  prev_d;
      logic [15:0] prev_i;
      build_exp(2);
      out_ready = 1'b0;
      send_cmd(2);
      n = 0; done = 1'b0; held = 1'b0; prev_d = '0; prev_i = '0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         checks++;
         if (out_valid !== 1'b1 || n >= exp_q.size() || out_data !== 7'(exp_q[n]) ||
             out_index !== 16'(n) || out_last !== (n == 20)) begin
            errors++;
            $display("FAIL stall_beat n=%0d got v=%b d=%h i=%0d l=%b", n, out_valid, out_data, out_index, out_last);
         end
         if (held) begin
            checks++;
            if (out_data !== prev_d || out_index !== prev_i) begin
               errors++;
               $display("FAIL stall_hold got d=%h i=%0d want d=%h i=%0d", out_data, out_index, prev_d, prev_i);
            end
         end
         if (out_ready) begin
            if (out_last) done = 1'b1;
            n++;
            held = 1'b0;
         end else begin
            held = 1'b1;
            prev_d = out_data;
            prev_i = out_index;
         end
         tick();
      end
      out_ready = 1'b1;
      checks++;
      if (!done || n != 21 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_end got done=%b beats=%0d v=%b want 1 21 0", done, n, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      out_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_k = 3'd1;
      tick();
      cmd_k = 3'd5;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cmd_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 7'(1 << i) || out_last !== (i == 6)) begin
            errors++;
            $display("FAIL busy_beat i=%0d got rdy=%b v=%b d=%h l=%b", i, cmd_ready, out_valid, out_data, out_last);
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_gap got v=%b rdy=%b want 0 1", out_valid, cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h1f || out_index !== 16'd0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_k5_first got v=%b d=%h i=%0d rdy=%b want 1 1f 0 0", out_valid, out_data, out_index, cmd_ready);
      end
      n = 0;
      while (out_valid === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      checks++;
      if (n != 21) begin
         errors++;
         $display("FAIL busy_k5_count got %0d want 21", n);
      end
   endtask

   task automatic test_rst_mid;
      build_exp(4);
      out_ready = 1'b1;
      send_cmd(4);
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (out_index !== 16'd10 || out_data !== 7'(exp_q[10])) begin
         errors++;
         $display("FAIL rst_pre got i=%0d d=%h want 10 %h", out_index, out_data, 7'(exp_q[10]));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || cmd_ready !== 1'b1 || out_index !== 16'd0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got v=%b rdy=%b i=%0d l=%b want 0 1 0 0", out_valid, cmd_ready, out_index, out_last);
      end
      send_cmd(4);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h0f || out_index !== 16'd0) begin
         errors++;
         $display("FAIL rst_restart got v=%b d=%h i=%0d want 1 0f 0", out_valid, out_data, out_index);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_n5_err;
      out_ready5 = 1'b0;
      cmd_valid5 = 1'b1;
      cmd_k5 = 3'd6;
      tick();
      cmd_valid5 = 1'b0;
      checks++;
      if (out_valid5 !== 1'b1 || out_data5 !== 5'd0 || out_err5 !== 1'b1 || out_last5 !== 1'b1 || out_index5 !== 16'd0) begin
         errors++;
         $display("FAIL n5_err got v=%b d=%h e=%b l=%b i=%0d want 1 0 1 1 0", out_valid5, out_data5, out_err5, out_last5, out_index5);
      end
      tick();
      checks++;
      if (out_valid5 !== 1'b1 || out_err5 !== 1'b1 || cmd_ready5 !== 1'b0) begin
         errors++;
         $display("FAIL n5_hold got v=%b e=%b rdy=%b want 1 1 0", out_valid5, out_err5, cmd_ready5);
      end
      out_ready5 = 1'b1;
      tick();
      checks++;
      if (out_valid5 !== 1'b0 || cmd_ready5 !== 1'b1) begin
         errors++;
         $display("FAIL n5_idle got v=%b rdy=%b want 0 1", out_valid5, cmd_ready5);
      end
      cmd_valid5 = 1'b1;
      cmd_k5 = 3'd5;
      tick();
      cmd_valid5 = 1'b0;
      checks++;
      if (out_data5 !== 5'h1f || out_last5 !== 1'b1 || out_err5 !== 1'b0) begin
         errors++;
         $display("FAIL n5_full got d=%h l=%b e=%b want 1f 1 0", out_data5, out_last5, out_err5);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_k3();
      test_sweep();
      test_stall();
      test_back_to_back();
      test_rst_mid();
      test_n5_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
